// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment display scanner.
package display_scan_ctrl_pkg;

  typedef logic [1:0] slot_t;

  localparam logic [3:0] ALL_OFF_ANODE = 4'hF;
  localparam logic [6:0] ALL_OFF_SEG   = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/display_scan_ctrl_seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment cathode pattern {g,f,e,d,c,b,a}.
module seg7_hex_decode (
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = 7'h7F;
    unique case (nibble)
      4'h0: seg_n = 7'h40;
      4'h1: seg_n = 7'h79;
      4'h2: seg_n = 7'h24;
      4'h3: seg_n = 7'h30;
      4'h4: seg_n = 7'h19;
      4'h5: seg_n = 7'h12;
      4'h6: seg_n = 7'h02;
      4'h7: seg_n = 7'h78;
      4'h8: seg_n = 7'h00;
      4'h9: seg_n = 7'h10;
      4'hA: seg_n = 7'h08;
      4'hB: seg_n = 7'h03;
      4'hC: seg_n = 7'h46;
      4'hD: seg_n = 7'h21;
      4'hE: seg_n = 7'h06;
      4'hF: seg_n = 7'h0E;
      default: seg_n = 7'h7F;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan of a 4-digit common-anode display with per-slot dead-time
// and once-per-frame shadowing of the displayed value.
//
// state | meaning
// IDLE  | scanning disabled, bus dark, cnt/slot parked at 0
// BLANK | start of a slot, all anodes off to suppress ghosting
// DRIVE | selected anode on with its decoded digit
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] digits,
  input  logic [3:0]  dp,
  input  logic [3:0]  blank_mask,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic [1:0]  digit_sel,
  output logic        frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  scan_state_e       state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  slot_t             slot, slot_nxt;
  logic              load_shadow;
  logic              frame_done_nxt;

  logic [3:0][3:0]   digits_sh;
  logic [3:0]        dp_sh;
  logic [3:0]        mask_sh;

  logic [3:0]        anode_nxt;
  logic [6:0]        seg_nxt;
  logic              dp_n_nxt;
  logic [6:0]        seg_dec;

  seg7_hex_decode u_decode (
    .nibble (digits_sh[slot]),
    .seg_n  (seg_dec)
  );

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    slot_nxt       = slot;
    load_shadow    = 1'b0;
    frame_done_nxt = 1'b0;

    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      slot_nxt  = '0;
    end else if (state == IDLE) begin
      cnt_nxt     = '0;
      slot_nxt    = '0;
      load_shadow = 1'b1;
      state_nxt   = (BLANK_CYCLES > 0) ? BLANK : DRIVE;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt_nxt  = '0;
        slot_nxt = slot_t'(slot + 2'd1);
        // Frame boundary: new value becomes visible starting at slot 0
        if (slot == 2'd3) begin
          load_shadow    = 1'b1;
          frame_done_nxt = 1'b1;
        end
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
      state_nxt = (int'(cnt_nxt) < BLANK_CYCLES) ? BLANK : DRIVE;
    end
  end

  always_comb begin
    anode_nxt = ALL_OFF_ANODE;
    seg_nxt   = ALL_OFF_SEG;
    dp_n_nxt  = 1'b1;
    if (state == DRIVE && !mask_sh[slot]) begin
      anode_nxt = ~(4'b0001 << slot);
      seg_nxt   = seg_dec;
      dp_n_nxt  = ~dp_sh[slot];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      slot       <= '0;
      digits_sh  <= '0;
      dp_sh      <= '0;
      mask_sh    <= '0;
      anode      <= ALL_OFF_ANODE;
      seg        <= ALL_OFF_SEG;
      dp_n       <= 1'b1;
      digit_sel  <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      slot       <= slot_nxt;
      if (load_shadow) begin
        digits_sh <= digits;
        dp_sh     <= dp;
        mask_sh   <= blank_mask;
      end
      anode      <= anode_nxt;
      seg        <= seg_nxt;
      dp_n       <= dp_n_nxt;
      digit_sel  <= slot;
      frame_done <= frame_done_nxt;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  blank_mask;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp_n;
  logic [1:0]  digit_sel;
  logic        frame_done;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  display_scan_ctrl #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .digits     (digits),
    .dp         (dp),
    .blank_mask (blank_mask),
    .anode      (anode),
    .seg        (seg),
    .dp_n       (dp_n),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  // Hand-decoded glyphs per slot {slot3, slot2, slot1, slot0}, then dp, then blank mask.
  typedef struct packed {
    logic [3:0][6:0] seg;
    logic [3:0]      dp;
    logic [3:0]      mask;
  } vec_set_t;

  // digits 1234, no dp, no mask
  localparam vec_set_t SET_A = {7'h79, 7'h24, 7'h30, 7'h19, 4'b0000, 4'b0000};
  // digits 5678, dp on slot 0, slot 3 blanked
  localparam vec_set_t SET_B = {7'h12, 7'h02, 7'h78, 7'h00, 4'b0001, 4'b1000};
  // digits 0F48, dp on slot 2, no mask
  localparam vec_set_t SET_C = {7'h40, 7'h0E, 7'h19, 7'h00, 4'b0100, 4'b0000};

  task automatic check_vec(input string tag, input int pos, input logic [15:0] obs,
                           input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s pos=%0d got=%h want=%h", tag, pos, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // pos = scan position the registered outputs reflect (cnt = pos%8, slot = pos/8%4);
  // pos < 0 means the outputs reflect IDLE/reset. Frame 0 uses s0, later frames s1.
  task automatic check_pos(input int pos, input vec_set_t s0, input vec_set_t s1);
    logic [3:0] e_an;
    logic [6:0] e_sg;
    logic       e_dp;
    logic [1:0] e_sel;
    logic       e_fd;
    vec_set_t   s;
    int         sl;
    e_an  = 4'hF;
    e_sg  = 7'h7F;
    e_dp  = 1'b1;
    e_sel = 2'd0;
    e_fd  = 1'b0;
    if (pos >= 0) begin
      sl    = (pos / 8) % 4;
      s     = (pos < 32) ? s0 : s1;
      e_sel = 2'(sl);
      e_fd  = ((pos % 32) == 31);
      if ((pos % 8) >= 2 && !s.mask[sl]) begin
        e_an = ~(4'b0001 << sl);
        e_sg = s.seg[sl];
        e_dp = ~s.dp[sl];
      end
    end
    check_vec("anode",      pos, 16'(anode),      16'(e_an));
    check_vec("seg",        pos, 16'(seg),        16'(e_sg));
    check_vec("dp_n",       pos, 16'(dp_n),       16'(e_dp));
    check_vec("digit_sel",  pos, 16'(digit_sel),  16'(e_sel));
    check_vec("frame_done", pos, 16'(frame_done), 16'(e_fd));
    check_vec("one_low",    pos, 16'($countones(~anode) <= 1), 16'd1);
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b1;
    digits     = 16'h1234;
    dp         = 4'b0000;
    blank_mask = 4'b0000;

    repeat (3) begin
      tick();
      check_pos(-1, SET_A, SET_A);
    end
    reset = 1'b0;

    // Frame 0 shows 1234; new inputs arrive in slot 1 and must wait for the frame edge.
    for (int m = 1; m <= 87; m++) begin
      tick();
      check_pos(m - 2, SET_A, SET_B);
      if (m == 12) begin
        digits     = 16'h5678;
        dp         = 4'b0001;
        blank_mask = 4'b1000;
      end
      if (m == 86) enable = 1'b0;
    end

    repeat (4) begin
      tick();
      check_pos(-1, SET_B, SET_B);
    end

    digits     = 16'h0F48;
    dp         = 4'b0100;
    blank_mask = 4'b0000;
    enable     = 1'b1;
    for (int m = 1; m <= 40; m++) begin
      tick();
      check_pos(m - 2, SET_C, SET_C);
    end

    // Reset mid-scan with enable still high.
    reset = 1'b1;
    repeat (2) begin
      tick();
      check_pos(-1, SET_C, SET_C);
    end
    reset = 1'b0;
    for (int m = 1; m <= 12; m++) begin
      tick();
      check_pos(m - 2, SET_C, SET_C);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
